// File: rtl/gomoku_pkg.sv
// -----------------------------------------------------------------------------
// gomoku_pkg
// Shared definitions for the Gomoku board display:
//   - default board geometry (cells per side, pixels per cell)
//   - cell_t : stone value held in each board cell
//   - pix_stage_t : per-pixel attributes carried down the render pipeline
//   - wr_state_t : states of the deferred board-write sequencer
//   - shared colour definitions, including COLOR_CURSOR
// -----------------------------------------------------------------------------
package gomoku_pkg;

    localparam int DEF_BOARD_N = 15;
    localparam int DEF_CELL_PX = 32;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        BLACK   = 2'd1,
        WHITE   = 2'd2,
        INVALID = 2'd3
    } cell_t;

    typedef enum logic [2:0] {
        WR_IDLE,
        WR_PEND,
        WR_COMMIT,
        WR_ACK,
        WR_DROP
    } wr_state_t;

    typedef struct packed {
        logic       in_board;
        logic       active;
        logic       hsync;
        logic       vsync;
        logic [5:0] local_h;
        logic [5:0] local_v;
    } pix_stage_t;

    // Syncs idle high, so an idle pipeline slot carries inactive syncs.
    localparam pix_stage_t PIX_IDLE = '{
        in_board: 1'b0, active: 1'b0, hsync: 1'b1, vsync: 1'b1,
        local_h: 6'd0, local_v: 6'd0
    };

    // Shared colour definitions (12-bit RGB 4:4:4).
    localparam logic [11:0] COLOR_EMPTY   = 12'hA73;
    localparam logic [11:0] COLOR_BLACK   = 12'h111;
    localparam logic [11:0] COLOR_WHITE   = 12'hEEE;
    localparam logic [11:0] COLOR_INVALID = 12'hF0F;
    localparam logic [11:0] COLOR_CURSOR  = 12'h0F0;

endpackage

// File: rtl/board_render_ctrl_if.sv
// -----------------------------------------------------------------------------
// board_render_ctrl_if
// Game-logic write/clear request bus into the board renderer.
//   wr_req   : write request, level, held until wr_ack
//   wr_row   : target row (values >= board size are acked and ignored)
//   wr_col   : target column (same rule as wr_row)
//   wr_value : stone value to store
//   clr_req  : clear-board request, level; wins over wr_req
//   wr_ack   : one-cycle acknowledge for either request
// Modports: master = game logic, slave = board_render_ctrl.
// -----------------------------------------------------------------------------
interface board_render_ctrl_if;

    logic       wr_req;
    logic [3:0] wr_row;
    logic [3:0] wr_col;
    logic [1:0] wr_value;
    logic       clr_req;
    logic       wr_ack;

    modport master (
        output wr_req, wr_row, wr_col, wr_value, clr_req,
        input  wr_ack
    );

    modport slave (
        input  wr_req, wr_row, wr_col, wr_value, clr_req,
        output wr_ack
    );

endinterface

// File: rtl/board_regfile.sv
// -----------------------------------------------------------------------------
// board_regfile
// N x N board store of 2-bit cell values.
//   clk, rst_n     : clock, asynchronous active-low reset (store resets to EMPTY)
//   rd_row, rd_col : read address; out-of-range reads return EMPTY
//   rd_data        : registered read data, valid the cycle after the address
//   we, wr_row, wr_col, wr_data : write port; out-of-range writes are ignored
//   clr            : clears every cell in a single cycle, overrides we
// A read in the same cycle as a write returns the old value.
// -----------------------------------------------------------------------------
module board_regfile
    import gomoku_pkg::*;
#(
    parameter int N = DEF_BOARD_N
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] rd_row,
    input  logic [3:0] rd_col,
    output cell_t      rd_data,
    input  logic       we,
    input  logic [3:0] wr_row,
    input  logic [3:0] wr_col,
    input  cell_t      wr_data,
    input  logic       clr
);

    localparam int DEPTH = N * N;
    localparam int AW    = $clog2(DEPTH);

    cell_t          mem_q [DEPTH];
    cell_t          rd_data_q;
    logic           rd_ok;
    logic           wr_ok;
    logic [AW-1:0]  rd_addr;
    logic [AW-1:0]  wr_addr;

    always_comb begin
        rd_ok   = (int'(rd_row) < N) && (int'(rd_col) < N);
        wr_ok   = (int'(wr_row) < N) && (int'(wr_col) < N);
        rd_addr = AW'(int'(rd_row) * N + int'(rd_col));
        wr_addr = AW'(int'(wr_row) * N + int'(wr_col));
    end

    // NOTE: the store is reset (and bulk-cleared) as a whole, so it is built
    // from resettable flops rather than a RAM macro, which has no reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= EMPTY;
        end else if (clr) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= EMPTY;
        end else if (we && wr_ok) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= EMPTY;
        end else begin
            rd_data_q <= rd_ok ? mem_q[rd_addr] : EMPTY;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/board_render_ctrl.sv
// -----------------------------------------------------------------------------
// board_render_ctrl
// Per-pixel board renderer: maps VGA coordinates to a board cell, fetches the
// cell's stone from the board store, drives the external colour LUT and
// returns registered RGB with syncs delayed to match (3-cycle latency).
// Game-logic writes/clears are held until vertical blanking so a frame never
// shows a half-updated board.
// Ports:
//   clk, rst_n              : pixel clock, asynchronous active-low reset
//   pix_h, pix_v            : current pixel coordinates
//   pix_active              : visible-area flag
//   hsync_in, vsync_in      : raw syncs (idle high)
//   lut_local_h/v           : in-cell pixel offset to the LUT
//   lut_cell_value          : cell value to the LUT (0 outside the board)
//   lut_rgb                 : LUT colour, combinational from the lut_* outputs
//   rgb                     : registered pixel colour (0 outside active video)
//   hsync_out, vsync_out    : syncs delayed to line up with rgb
//   wr_bus                  : write/clear request bus (slave side)
// Optional feature macro BOARD_CURSOR_EN: adds cursor_row/cursor_col inputs
// and draws a COLOR_CURSOR frame two pixels wide inside the cursor cell.
// -----------------------------------------------------------------------------
module board_render_ctrl
    import gomoku_pkg::*;
#(
    parameter int BOARD_N  = DEF_BOARD_N,
    parameter int CELL_PX  = DEF_CELL_PX,
    parameter int ORIGIN_H = 80,
    parameter int ORIGIN_V = 0,
    parameter int V_ACTIVE = 480
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  pix_h,
    input  logic [9:0]  pix_v,
    input  logic        pix_active,
    input  logic        hsync_in,
    input  logic        vsync_in,
    output logic [5:0]  lut_local_v,
    output logic [5:0]  lut_local_h,
    output logic [1:0]  lut_cell_value,
    input  logic [11:0] lut_rgb,
    output logic [11:0] rgb,
    output logic        hsync_out,
    output logic        vsync_out,
`ifdef BOARD_CURSOR_EN
    input  logic [3:0]  cursor_row,
    input  logic [3:0]  cursor_col,
`endif
    board_render_ctrl_if.slave wr_bus
);

    localparam int         CELL_LOG   = $clog2(CELL_PX);
    localparam logic [9:0] BOARD_PX   = 10'(BOARD_N * CELL_PX);
    localparam logic [9:0] LOCAL_MASK = 10'(CELL_PX - 1);

    // ---------------------------------------------------------------- stage 0
    // Offsets are 11-bit two's complement: bit 10 set means left of / above
    // the board origin.
    logic signed [10:0] off_h;
    logic signed [10:0] off_v;
    logic [3:0]         row_d;
    logic [3:0]         col_d;
    pix_stage_t         s0_d;

    // NOTE: every variable written here gets a value before any branch can
    // skip it, so no latch is inferred.
    always_comb begin
        off_h = 11'({1'b0, pix_h}) - 11'(ORIGIN_H);
        off_v = 11'({1'b0, pix_v}) - 11'(ORIGIN_V);
        col_d = 4'(off_h[9:0] >> CELL_LOG);
        row_d = 4'(off_v[9:0] >> CELL_LOG);

        s0_d          = PIX_IDLE;
        s0_d.in_board = pix_active
                        && !off_h[10] && (off_h[9:0] < BOARD_PX)
                        && !off_v[10] && (off_v[9:0] < BOARD_PX);
        s0_d.active   = pix_active;
        s0_d.hsync    = hsync_in;
        s0_d.vsync    = vsync_in;
        s0_d.local_h  = 6'(off_h[9:0] & LOCAL_MASK);
        s0_d.local_v  = 6'(off_v[9:0] & LOCAL_MASK);
    end

    pix_stage_t  s0_q;
    pix_stage_t  s1_q;
    logic [3:0]  s0_row_q;
    logic [3:0]  s0_col_q;
    logic [9:0]  pix_v_q;
    logic [11:0] rgb_d;
    logic [11:0] rgb_q;
    logic        hsync_q;
    logic        vsync_q;

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples the previous stage's value from before this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_q     <= PIX_IDLE;
            s0_row_q <= 4'd0;
            s0_col_q <= 4'd0;
            pix_v_q  <= 10'd0;
            s1_q     <= PIX_IDLE;
            rgb_q    <= 12'h000;
            hsync_q  <= 1'b1;
            vsync_q  <= 1'b1;
        end else begin
            s0_q     <= s0_d;
            s0_row_q <= row_d;
            s0_col_q <= col_d;
            pix_v_q  <= pix_v;
            s1_q     <= s0_q;
            rgb_q    <= rgb_d;
            hsync_q  <= s1_q.hsync;
            vsync_q  <= s1_q.vsync;
        end
    end

    // ------------------------------------------------------- board store
    wr_state_t  state_q, state_d;
    logic [3:0] req_row_q, req_row_d;
    logic [3:0] req_col_q, req_col_d;
    cell_t      req_val_q, req_val_d;
    logic       req_clr_q, req_clr_d;
    logic       cell_we;
    logic       cell_clr;
    cell_t      cell_rd;

    // Stage 1: synchronous read lines up with s1_q.
    board_regfile #(
        .N (BOARD_N)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_row  (s0_row_q),
        .rd_col  (s0_col_q),
        .rd_data (cell_rd),
        .we      (cell_we),
        .wr_row  (req_row_q),
        .wr_col  (req_col_q),
        .wr_data (req_val_q),
        .clr     (cell_clr)
    );

    // ---------------------------------------------------------------- stage 2
    assign lut_local_h    = s1_q.local_h;
    assign lut_local_v    = s1_q.local_v;
    assign lut_cell_value = s1_q.in_board ? cell_rd : EMPTY;

`ifdef BOARD_CURSOR_EN
    localparam logic [5:0] EDGE_HI = 6'(CELL_PX - 2);

    logic cur_d;
    logic cur0_q;
    logic cur1_q;

    always_comb begin
        cur_d = s0_d.in_board && (row_d == cursor_row) && (col_d == cursor_col)
                && ((s0_d.local_h < 6'd2) || (s0_d.local_h >= EDGE_HI)
                 || (s0_d.local_v < 6'd2) || (s0_d.local_v >= EDGE_HI));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur0_q <= 1'b0;
            cur1_q <= 1'b0;
        end else begin
            cur0_q <= cur_d;
            cur1_q <= cur0_q;
        end
    end

    always_comb begin
        rgb_d = 12'h000;
        if (s1_q.active) rgb_d = cur1_q ? COLOR_CURSOR : lut_rgb;
    end
`else
    always_comb begin
        rgb_d = s1_q.active ? lut_rgb : 12'h000;
    end
`endif

    assign rgb       = rgb_q;
    assign hsync_out = hsync_q;
    assign vsync_out = vsync_q;

    // ------------------------------------------------- deferred write FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= WR_IDLE;
            req_row_q <= 4'd0;
            req_col_q <= 4'd0;
            req_val_q <= EMPTY;
            req_clr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_row_q <= req_row_d;
            req_col_q <= req_col_d;
            req_val_q <= req_val_d;
            req_clr_q <= req_clr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_row_d = req_row_q;
        req_col_d = req_col_q;
        req_val_d = req_val_q;
        req_clr_d = req_clr_q;
        cell_we   = 1'b0;
        cell_clr  = 1'b0;
        unique case (state_q)
            WR_IDLE: begin
                if (wr_bus.clr_req || wr_bus.wr_req) begin
                    state_d   = WR_PEND;
                    req_row_d = wr_bus.wr_row;
                    req_col_d = wr_bus.wr_col;
                    req_val_d = cell_t'(wr_bus.wr_value);
                    req_clr_d = wr_bus.clr_req;
                end
            end
            // The registered line number keeps the commit decision aligned
            // with the pixel pipeline rather than the raw input.
            WR_PEND: begin
                if (pix_v_q >= 10'(V_ACTIVE)) state_d = WR_COMMIT;
            end
            WR_COMMIT: begin
                cell_clr = req_clr_q;
                cell_we  = !req_clr_q;
                state_d  = WR_ACK;
            end
            WR_ACK: begin
                state_d = WR_DROP;
            end
            // Wait for the requester to let go so one level request is
            // never serviced twice.
            WR_DROP: begin
                if (!wr_bus.wr_req && !wr_bus.clr_req) state_d = WR_IDLE;
            end
            default: begin
                state_d = WR_IDLE;
            end
        endcase
    end

    assign wr_bus.wr_ack = (state_q == WR_ACK);

endmodule

// File: doc/board_render_ctrl.md
# board_render_ctrl

Sequences the per-pixel cell-colour lookup for the Gomoku board display. It takes VGA pixel coordinates and syncs and converts them to a board cell and in-cell offsets. It fetches the cell's stone value from an internal 15×15 board store, drives the combinational cell-colour LUT, and returns registered RGB with syncs delayed to match. It also arbitrates game-logic writes into the board store, deferring each write to vertical blanking so a frame never shows a half-updated board.

## Interface
- `BOARD_N`, 15: cells per side.
- `CELL_PX`, 32: pixels per cell side. Power of two, ≤ 64.
- `ORIGIN_H`, 80: horizontal pixel of the board's left edge.
- `ORIGIN_V`, 0: vertical pixel of the board's top edge.
- `V_ACTIVE`, 480: first non-visible line. Lines `pix_v ≥ V_ACTIVE` are vblank.

- `clk`  in  1  pixel clock
- `rst_n`  in  1  asynchronous, active-low reset
- `pix_h`, `pix_v`  in  10 each  current pixel coordinates
- `pix_active`  in  1  visible-area flag
- `hsync_in`, `vsync_in`  in  1 each  raw syncs
- `lut_local_v`, `lut_local_h`  out  6 each  in-cell offset to LUT
- `lut_cell_value`  out  2  cell value to LUT
- `lut_rgb`  in  12  LUT colour, combinational from the three outputs above
- `rgb`  out  12  registered pixel colour
- `hsync_out`, `vsync_out`  out  1 each  syncs delayed to match `rgb`
- `wr_req`  in  1  write request, level
- `wr_row`, `wr_col`  in  4 each  target cell
- `wr_value`  in  2  value to store
- `clr_req`  in  1  clear-board request, level
- `wr_ack`  out  1  one-cycle acknowledge for either request

## Operation
- Stage 0 registers the inputs and computes these values:
  - `in_board` = `pix_active` && `pix_h − ORIGIN_H` in [0, BOARD_N·CELL_PX) && `pix_v − ORIGIN_V` in [0, BOARD_N·CELL_PX).
  - `col` and `row` = offset >> log2(CELL_PX).
  - `local_h` and `local_v` = offset & (CELL_PX−1), zero-extended to 6 bits.
  - Subtraction is 11-bit signed; a negative result means outside the board.
- Stage 1 reads the board store at (row, col). The read is synchronous. `in_board`, locals and syncs are carried forward.
- Stage 2 drives the `lut_*` outputs:
  - `lut_cell_value` = 0 when not `in_board`.
  - `rgb` ← `lut_rgb` when `pix_active`, else 12'h000.
  - Out-of-board but active pixels therefore show the empty-cell colour.
- Writes use a state machine with states IDLE, PEND, COMMIT, ACK, DROP:
  - IDLE → PEND on `clr_req` or `wr_req`. Row, col, value and the clear flag are latched. `clr_req` wins if both are high.
  - PEND → COMMIT when the registered `pix_v ≥ V_ACTIVE`.
  - COMMIT writes one cell, or clears all cells to 0. The write lands in one cycle → ACK.
  - ACK drives `wr_ack` = 1 for one cycle → DROP.
  - DROP waits until both requests are low → IDLE. Requesters must deassert after `wr_ack`.
- Out-of-range `wr_row`/`wr_col` (≥ BOARD_N) are acked with no store change.
- `wr_value` 2'b11 is stored as-is; the LUT renders it as the error colour.
- A request arriving during vblank is committed within 2 cycles.

## Timing
- Pixel latency is 3 cycles, pixel in to `rgb`. `hsync_out`/`vsync_out` are delayed exactly 3 cycles.
- A write is visible from the first pixel read at least 1 cycle after COMMIT.
- Reset values:
  - `rgb` = 0, `wr_ack` = 0, `lut_*` = 0.
  - Sync pipeline = 1, i.e. sync inactive-high idle.
  - Board store all 0; FSM in IDLE.
- Reset mid-request drops the request with no ack. The requester re-issues it after reset.

## Configuration
- `BOARD_CURSOR_EN` defined:
  - Adds inputs `cursor_row`, `cursor_col` (4 bits each).
  - Pixels in that cell with `local_h` or `local_v` < 2 or ≥ CELL_PX−2 output `COLOR_CURSOR` instead of `lut_rgb`.
  - The cursor is registered in stage 0, so latency is unchanged.
- Undefined: cursor ports and logic are absent.

## Structure
- Shared package `gomoku_pkg` holds:
  - `BOARD_N` and `CELL_PX` defaults.
  - The cell value enum `cell_t` {EMPTY=0, BLACK=1, WHITE=2, INVALID=3}.
- `COLOR_CURSOR` goes in the shared colour definitions.
- One sub-module, `board_regfile`: BOARD_N² × 2-bit store with one synchronous read port, one write port, and a single-cycle clear.

## Test plan
- Reset, then a full frame with an empty board → every active board pixel equals the LUT empty colour; `rgb` = 0 in blanking; syncs lag by 3 cycles.
- `wr_req` with row 7, col 7, value 1 asserted at `pix_v` = 100 → no `wr_ack` until `pix_v` = 480. Ack one cycle after COMMIT. The next frame shows black at pixels h 304–335, v 224–255.
- `clr_req` and `wr_req` both high → clear wins. One ack is issued, all cells read 0, and the FSM holds in DROP until both requests are low.
- `wr_row` = 15 → ack issued, store unchanged.
- Pixel h = 79 and h = 560 active → `lut_cell_value` = 0. Pixel h = 80, v = 0 → row 0, col 0, locals 0.
- With `BOARD_CURSOR_EN` and cursor (0,0): pixel (81,1) = `COLOR_CURSOR`; pixel (90,10) = cell colour.
